// File: rtl/fsm_seq_detect.sv
// Serial pattern detector with a runtime-loadable pattern and length.
// Supports overlapping and non-overlapping modes, an input qualifier and a saturating match count.
module fsm_seq_detect #(
  parameter int unsigned          MAX_LEN = 8,
  parameter int unsigned          CNT_W   = 8,
  parameter logic [MAX_LEN-1:0]   RST_PAT = MAX_LEN'(8'b0000_1011),
  parameter int unsigned          RST_LEN = 4,
  parameter int unsigned          LEN_W   = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               load,
  input  logic [MAX_LEN-1:0] pat_in,
  input  logic [LEN_W-1:0]   len_in,
  input  logic               overlap,
  input  logic               en,
  input  logic               x,
  input  logic               cnt_clr,
  output logic               z,
  output logic [CNT_W-1:0]   count,
  output logic               cfg_ok
);

  localparam int unsigned FILL_MAX = MAX_LEN - 1;

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               cfg_ok_q, cfg_ok_d;
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [MAX_LEN-1:0] window_c;
  logic [MAX_LEN-1:0] mask_c;
  logic               fill_ok_c;
  logic               hit_c;
  logic               z_c;

  function automatic logic len_valid(input logic [LEN_W-1:0] len);
    return (len >= LEN_W'(1)) && (len <= LEN_W'(MAX_LEN));
  endfunction

  // Compare the newest len_q bits of the stream against the low bits of the pattern.
  always_comb begin
    window_c = {hist_q, x};
    mask_c   = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      mask_c[i] = (LEN_W'(i) < len_q);
    end
    fill_ok_c = ({1'b0, fill_q} + (LEN_W + 1)'(1)) >= {1'b0, len_q};
    hit_c     = ((window_c ^ pat_q) & mask_c) == '0;
    z_c       = !clr && en && !load && cfg_ok_q && fill_ok_c && hit_c;
  end

  // Next-state: load outranks cnt_clr, which outranks the normal shift/count update.
  always_comb begin
    pat_d    = pat_q;
    len_d    = len_q;
    cfg_ok_d = cfg_ok_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    count_d  = count_q;
    if (load) begin
      pat_d    = pat_in;
      len_d    = len_in;
      cfg_ok_d = len_valid(len_in);
      hist_d   = '0;
      fill_d   = '0;
    end else begin
      if (cnt_clr) begin
        count_d = '0;
      end else if (z_c && (count_q != '1)) begin
        count_d = count_q + CNT_W'(1);
      end
      if (en) begin
        hist_d = window_c[MAX_LEN-2:0];
        if (z_c && !overlap) begin
          fill_d = '0;
        end else if (fill_q < LEN_W'(FILL_MAX)) begin
          fill_d = fill_q + LEN_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pat_q    <= RST_PAT;
      len_q    <= LEN_W'(RST_LEN);
      cfg_ok_q <= len_valid(LEN_W'(RST_LEN));
      hist_q   <= '0;
      fill_q   <= '0;
      count_q  <= '0;
    end else begin
      pat_q    <= pat_d;
      len_q    <= len_d;
      cfg_ok_q <= cfg_ok_d;
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      count_q  <= count_d;
    end
  end

  assign z      = z_c;
  assign count  = count_q;
  assign cfg_ok = cfg_ok_q;

endmodule

// File: tb/tb_fsm_seq_detect.sv
// Directed bench for fsm_seq_detect: a default instance and a 2-bit-counter instance share one stimulus.
module tb_fsm_seq_detect;

  logic       clk = 1'b0;
  logic       clr, load, overlap, en, x, cnt_clr;
  logic [7:0] pat_in;
  logic [3:0] len_in;
  logic       z, z2, cfg_ok, cfg_ok2;
  logic [7:0] count;
  logic [1:0] count2;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  fsm_seq_detect dut (
    .clk(clk), .clr(clr), .load(load), .pat_in(pat_in), .len_in(len_in),
    .overlap(overlap), .en(en), .x(x), .cnt_clr(cnt_clr),
    .z(z), .count(count), .cfg_ok(cfg_ok)
  );

  fsm_seq_detect #(.CNT_W(2)) dut_c2 (
    .clk(clk), .clr(clr), .load(load), .pat_in(pat_in), .len_in(len_in),
    .overlap(overlap), .en(en), .x(x), .cnt_clr(cnt_clr),
    .z(z2), .count(count2), .cfg_ok(cfg_ok2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one bit at the falling edge, check z mid-cycle, return just after the rising edge.
  task automatic bit_in(input logic xb, input logic ev, input logic ez, input string tag);
    @(negedge clk);
    x  = xb;
    en = ev;
    #2;
    chk({tag, " z"},  32'(z),  32'(ez));
    chk({tag, " z2"}, 32'(z2), 32'(ez));
    @(posedge clk);
    #1;
  endtask

  task automatic gap3(input string tag);
    bit_in(1'b1, 1'b0, 1'b0, tag);
    bit_in(1'b0, 1'b0, 1'b0, tag);
    bit_in(1'b1, 1'b0, 1'b0, tag);
  endtask

  // Load with a live x=1 bit that must be discarded.
  task automatic do_load(input logic [7:0] p, input logic [3:0] l);
    @(negedge clk);
    load   = 1'b1;
    pat_in = p;
    len_in = l;
    en     = 1'b1;
    x      = 1'b1;
    #2;
    chk("load z", 32'(z), 0);
    @(posedge clk);
    #1;
    load = 1'b0;
    en   = 1'b0;
  endtask

  task automatic clr_cnt();
    @(negedge clk);
    en      = 1'b0;
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    chk("cnt_clr count", 32'(count), 0);
  endtask

  initial begin
    clr = 1'b1; load = 1'b0; overlap = 1'b1; en = 1'b1; x = 1'b1; cnt_clr = 1'b0;
    pat_in = 8'h00; len_in = 4'd0;
    #3;
    chk("reset z", 32'(z), 0);
    chk("reset count", 32'(count), 0);
    chk("reset cfg_ok", 32'(cfg_ok), 1);
    #9;
    clr = 1'b0;
    en  = 1'b0;

    // Overlapping 1011 out of reset
    bit_in(1'b1, 1'b1, 1'b0, "ov b1");
    bit_in(1'b0, 1'b1, 1'b0, "ov b2");
    bit_in(1'b1, 1'b1, 1'b0, "ov b3");
    bit_in(1'b1, 1'b1, 1'b1, "ov b4");
    bit_in(1'b0, 1'b1, 1'b0, "ov b5");
    bit_in(1'b1, 1'b1, 1'b0, "ov b6");
    bit_in(1'b1, 1'b1, 1'b1, "ov b7");
    chk("ov count", 32'(count), 2);
    chk("ov count2", 32'(count2), 2);

    // Non-overlapping 1011
    overlap = 1'b0;
    do_load(8'h0B, 4'd4);
    clr_cnt();
    bit_in(1'b1, 1'b1, 1'b0, "nov b1");
    bit_in(1'b0, 1'b1, 1'b0, "nov b2");
    bit_in(1'b1, 1'b1, 1'b0, "nov b3");
    bit_in(1'b1, 1'b1, 1'b1, "nov b4");
    bit_in(1'b0, 1'b1, 1'b0, "nov b5");
    bit_in(1'b1, 1'b1, 1'b0, "nov b6");
    bit_in(1'b1, 1'b1, 1'b0, "nov b7");
    chk("nov count", 32'(count), 1);
    do_load(8'h0B, 4'd4);
    clr_cnt();
    bit_in(1'b1, 1'b1, 1'b0, "nov2 b1");
    bit_in(1'b0, 1'b1, 1'b0, "nov2 b2");
    bit_in(1'b1, 1'b1, 1'b0, "nov2 b3");
    bit_in(1'b1, 1'b1, 1'b1, "nov2 b4");
    bit_in(1'b1, 1'b1, 1'b0, "nov2 b5");
    bit_in(1'b0, 1'b1, 1'b0, "nov2 b6");
    bit_in(1'b1, 1'b1, 1'b0, "nov2 b7");
    bit_in(1'b1, 1'b1, 1'b1, "nov2 b8");
    chk("nov2 count", 32'(count), 2);

    // Mid-stream load of pattern 11: old history must not contribute
    overlap = 1'b1;
    do_load(8'h0B, 4'd4);
    clr_cnt();
    bit_in(1'b1, 1'b1, 1'b0, "pre b1");
    bit_in(1'b0, 1'b1, 1'b0, "pre b2");
    bit_in(1'b1, 1'b1, 1'b0, "pre b3");
    do_load(8'h03, 4'd2);
    bit_in(1'b1, 1'b1, 1'b0, "l2ov b1");
    bit_in(1'b1, 1'b1, 1'b1, "l2ov b2");
    bit_in(1'b1, 1'b1, 1'b1, "l2ov b3");
    chk("l2ov count", 32'(count), 2);
    overlap = 1'b0;
    do_load(8'h03, 4'd2);
    bit_in(1'b1, 1'b1, 1'b0, "l2nov b1");
    bit_in(1'b1, 1'b1, 1'b1, "l2nov b2");
    bit_in(1'b1, 1'b1, 1'b0, "l2nov b3");
    bit_in(1'b1, 1'b1, 1'b1, "l2nov b4");

    // en gaps with x toggling while invalid
    overlap = 1'b1;
    do_load(8'h0B, 4'd4);
    clr_cnt();
    bit_in(1'b1, 1'b1, 1'b0, "gap b1");
    gap3("gap idle1");
    bit_in(1'b0, 1'b1, 1'b0, "gap b2");
    gap3("gap idle2");
    bit_in(1'b1, 1'b1, 1'b0, "gap b3");
    gap3("gap idle3");
    bit_in(1'b1, 1'b1, 1'b1, "gap b4");
    chk("gap count", 32'(count), 1);

    // Counter saturation on the 2-bit instance
    do_load(8'h03, 4'd2);
    clr_cnt();
    bit_in(1'b1, 1'b1, 1'b0, "sat b1");
    chk("sat c0", 32'(count2), 0);
    bit_in(1'b1, 1'b1, 1'b1, "sat b2");
    chk("sat c1", 32'(count2), 1);
    bit_in(1'b1, 1'b1, 1'b1, "sat b3");
    chk("sat c2", 32'(count2), 2);
    bit_in(1'b1, 1'b1, 1'b1, "sat b4");
    chk("sat c3", 32'(count2), 3);
    bit_in(1'b1, 1'b1, 1'b1, "sat b5");
    chk("sat c3 hold", 32'(count2), 3);
    chk("sat wide", 32'(count), 4);

    // cnt_clr coincident with a match
    cnt_clr = 1'b1;
    bit_in(1'b1, 1'b1, 1'b1, "cc b1");
    cnt_clr = 1'b0;
    chk("cc count", 32'(count), 0);
    chk("cc count2", 32'(count2), 0);
    bit_in(1'b1, 1'b1, 1'b1, "cc b2");
    chk("cc count after", 32'(count), 1);

    // Out-of-range lengths disable detection and freeze the count
    do_load(8'h03, 4'd0);
    chk("len0 cfg_ok", 32'(cfg_ok), 0);
    bit_in(1'b1, 1'b1, 1'b0, "len0 b1");
    bit_in(1'b1, 1'b1, 1'b0, "len0 b2");
    bit_in(1'b1, 1'b1, 1'b0, "len0 b3");
    chk("len0 count", 32'(count), 1);
    do_load(8'h03, 4'd9);
    chk("len9 cfg_ok", 32'(cfg_ok), 0);
    chk("len9 cfg_ok2", 32'(cfg_ok2), 0);
    bit_in(1'b1, 1'b1, 1'b0, "len9 b1");
    bit_in(1'b0, 1'b1, 1'b0, "len9 b2");
    bit_in(1'b1, 1'b1, 1'b0, "len9 b3");
    chk("len9 count", 32'(count), 1);

    // Asynchronous clr between edges restores defaults immediately
    #1;
    clr = 1'b1;
    en  = 1'b1;
    x   = 1'b1;
    #1;
    chk("aclr count", 32'(count), 0);
    chk("aclr cfg_ok", 32'(cfg_ok), 1);
    chk("aclr z", 32'(z), 0);
    #1;
    clr = 1'b0;
    bit_in(1'b1, 1'b1, 1'b0, "post b4");
    bit_in(1'b1, 1'b1, 1'b0, "post b1");
    bit_in(1'b0, 1'b1, 1'b0, "post b2");
    bit_in(1'b1, 1'b1, 1'b0, "post b3");
    bit_in(1'b1, 1'b1, 1'b1, "post b4m");
    chk("post count", 32'(count), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
